conv_output_collector: RTL
==========================

// Module: conv_output_collector
// PURPOSE
//   Sink end of the convolution stream: accepts one signed 16-bit convolved pixel per handshake from the
//   clocked convolution engine, writes it row-major into an internal output feature-map RAM, and flags done
//   after the last pixel. A 1-cycle registered read port gives the next layer or the host the stored map.
// PARAMETERS
//   N        32  maximum input image side; output RAM depth is N*N words
//   DATA_W   16  pixel width, signed two's complement
//   MAX_F    5   maximum filter side; legal filter sides are 1, 3 and 5
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high; clears all state except RAM contents
//   start       in   1       1-cycle pulse: latch sizes, clear counters, begin collection
//   imgSize     in   16      input image side, sampled on start
//   filterSize  in   16      filter side, sampled on start
//   in_valid    in   1       in_data holds a convolved pixel
//   in_data     in   DATA_W  convolved pixel, signed
//   in_ready    out  1       collector accepts in_data this cycle
//   rd_addr     in   $clog2(N*N)  read address (row*outSize + col)
//   rd_data     out  DATA_W  RAM word at rd_addr, registered
//   outSize     out  16      latched imgSize - filterSize + 1
//   wr_count    out  $clog2(N*N)+1  pixels accepted since start
//   done        out  1       all outSize*outSize pixels stored; held until start or reset
//   err_config  out  1       last start carried an illegal configuration
//   err_overrun out  1       sticky: in_valid asserted while in DONE
// BEHAVIOUR
//   Reset values: in_ready=0, rd_data=0, outSize=0, wr_count=0, done=0, err_config=0, err_overrun=0.
//   Internal row, col, wr_addr and state are cleared to 0 and IDLE. RAM contents are not cleared.
//   FSM states: IDLE, COLLECT, DONE.
//     In any state, start validates the configuration. It is legal when filterSize is in {1,3,5},
//       1 <= imgSize <= N, and filterSize <= imgSize.
//       legal -> COLLECT; latch outSize, zero row/col/wr_addr/wr_count, clear done/err_config/err_overrun.
//       illegal -> IDLE; err_config=1, done=0, outSize unchanged.
//     start during COLLECT aborts the current frame and restarts. Partial RAM data is left in place.
//     COLLECT: in_ready=1. A transfer happens when in_valid && in_ready.
//       On a transfer: mem[wr_addr] <= in_data; wr_addr++; wr_count++.
//       col++; when col == outSize-1, col <= 0 and row++.
//       The transfer with row == outSize-1 and col == outSize-1 moves the FSM to DONE.
//       done rises on the next edge and in_ready drops on that same edge.
//     DONE: in_ready=0 and in_data is ignored. in_valid=1 sets err_overrun (sticky).
//     IDLE: in_ready=0; in_valid is ignored and does not set any error.
//   Addressing: wr_addr is an incremental counter; there is no multiplier.
//     The map is packed with stride outSize, not N.
//   Read port: rd_data <= mem[rd_addr] every cycle in every state, latency 1.
//     A simultaneous write and read to the same address returns the old data (read-first).
//     rd_addr >= outSize*outSize returns whatever the RAM holds at that address.
//   start and a transfer in the same cycle: start wins and the pixel is dropped.
//     in_ready is 1 in that cycle only if the FSM was already in COLLECT.
//   reset asserted mid-frame clears state immediately (asynchronous). Data already written stays in RAM.
//   Widths: imgSize-filterSize+1 is computed in 16 bits only after the legality check, so it cannot underflow.
// STRUCTURE
//   cnn_pkg (shared with the convolution engine) holds:
//     DATA_W, N, MAX_F, the collector state enum coll_state_t {IDLE, COLLECT, DONE},
//     and a function f_out_size(img, flt).
//   Sub-module fmap_ram: N*N x DATA_W, one synchronous write port and one registered read port.
//     Read-first behaviour; no reset on the array.
//   Top level: FSM, row/col/wr_addr/wr_count counters, configuration check, error flags.
// TESTING
//   1. imgSize=8, filterSize=3, start, then 36 back-to-back pixels of value k-18 (k=0..35).
//      Expect outSize=6, wr_count=36, done=1 one cycle after the 36th transfer.
//      Reading addresses 0..35 returns -18..17, each one cycle after the address is applied.
//   2. imgSize=32, filterSize=5, in_valid toggled every other cycle.
//      Expect outSize=28, exactly 784 transfers, done only after the 784th; mem[783] holds the last pixel.
//   3. Illegal starts: filterSize=4; filterSize=5 with imgSize=3; imgSize=33.
//      Each gives err_config=1, FSM stays IDLE, in_ready=0.
//      A following legal start clears err_config.
//   4. Reach DONE, then drive in_valid=1 with 0x7FFF.
//      Expect err_overrun=1 and all 36 words unchanged; a new start clears both done and err_overrun.
//   5. Assert reset asynchronously after 10 of 36 pixels.
//      Outputs go to reset values immediately and words 0..9 are still readable.
//      After a restart, the first new pixel lands at address 0.
//   6. Pulse start in the same cycle as a transfer in COLLECT.
//      The pixel is dropped and wr_count=0; a write and read to the same address in one cycle returns the old value.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN stream definitions: sizes, collector state encoding and configuration helpers.
package cnn_pkg;

    localparam int unsigned N      = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned MAX_F  = 5;
    localparam int unsigned CFG_W  = 16;
    localparam int unsigned DEPTH  = N * N;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } coll_state_t;

    // Only meaningful once f_cfg_legal has passed, so it never underflows.
    function automatic logic [CFG_W-1:0] f_out_size(input logic [CFG_W-1:0] img,
                                                    input logic [CFG_W-1:0] flt);
        return CFG_W'(img - flt + CFG_W'(1));
    endfunction

    function automatic logic f_cfg_legal(input logic [CFG_W-1:0] img,
                                         input logic [CFG_W-1:0] flt);
        logic flt_ok;
        flt_ok = (flt == CFG_W'(1)) || (flt == CFG_W'(3)) || (flt == CFG_W'(5));
        return flt_ok && (flt <= CFG_W'(MAX_F)) && (img >= CFG_W'(1))
               && (img <= CFG_W'(N)) && (flt <= img);
    endfunction

endpackage

// File: rtl/fmap_ram.sv
// Output feature-map RAM: one synchronous write port, one registered read-first read port.
module fmap_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array is never reset; stored maps survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the same edge returns the pre-write word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_output_collector.sv
// Sink of the convolution stream: stores pixels row-major into the feature-map RAM and flags completion.
module conv_output_collector
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CFG_W-1:0]  imgSize,
    input  logic [CFG_W-1:0]  filterSize,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CFG_W-1:0]  outSize,
    output logic [CNT_W-1:0]  wr_count,
    output logic              done,
    output logic              err_config,
    output logic              err_overrun
);

    coll_state_t       state;
    logic [CFG_W-1:0]  row;
    logic [CFG_W-1:0]  col;
    logic [ADDR_W-1:0] wr_addr;
    logic              cfg_ok;
    logic              xfer;
    logic              we;
    logic              last_col;
    logic              last_row;

    assign cfg_ok   = f_cfg_legal(imgSize, filterSize);
    assign xfer     = in_valid && in_ready;
    // start takes priority: a pixel offered alongside start is dropped.
    assign we       = xfer && !start;
    assign last_col = (col == outSize - CFG_W'(1));
    assign last_row = (row == outSize - CFG_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            wr_addr     <= '0;
            wr_count    <= '0;
            outSize     <= '0;
            in_ready    <= 1'b0;
            done        <= 1'b0;
            err_config  <= 1'b0;
            err_overrun <= 1'b0;
        end else if (start) begin
            if (cfg_ok) begin
                state       <= COLLECT;
                outSize     <= f_out_size(imgSize, filterSize);
                row         <= '0;
                col         <= '0;
                wr_addr     <= '0;
                wr_count    <= '0;
                in_ready    <= 1'b1;
                done        <= 1'b0;
                err_config  <= 1'b0;
                err_overrun <= 1'b0;
            end else begin
                state      <= IDLE;
                in_ready   <= 1'b0;
                done       <= 1'b0;
                err_config <= 1'b1;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        wr_addr  <= wr_addr + ADDR_W'(1);
                        wr_count <= wr_count + CNT_W'(1);
                        if (last_col) begin
                            col <= '0;
                            row <= row + CFG_W'(1);
                            if (last_row) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            col <= col + CFG_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (in_valid) begin
                        err_overrun <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    fmap_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wr_addr(wr_addr),
        .wr_data(in_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule
